// File: rtl/dp_types_pkg.sv
// Shared datapath types: machine word and 2-bit branch direction counter.
package dp_types_pkg;

  typedef logic [31:0] word_t;

  // Encoded so that bit 1 alone gives the taken prediction.
  typedef enum logic [1:0] {
    NH = 2'b00,
    NS = 2'b01,
    TS = 2'b10,
    TH = 2'b11
  } bpred_t;

endpackage : dp_types_pkg

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with a 2-bit direction counter per entry.
// Lookup is combinational from the current fetch PC; updates from branch
// resolution are written on the next rising edge (no write-through bypass).
// Optional build macro BTB_STATS_EN adds lookup/hit/mispredict counters.
module branch_target_buffer #(
  parameter int unsigned ENTRIES = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_npc,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken
`ifdef BTB_STATS_EN
  ,
  output logic [31:0] stat_lookups,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_mispredicts
`endif
);

  import dp_types_pkg::*;

  localparam int unsigned IDXW = $clog2(ENTRIES);
  localparam int unsigned TAGW = 32 - IDXW - 2;

  logic [ENTRIES-1:0] valid_q;
  logic [TAGW-1:0]    tag_q    [ENTRIES];
  word_t              target_q [ENTRIES];
  bpred_t             state_q  [ENTRIES];

  logic [IDXW-1:0] lk_idx;
  logic [TAGW-1:0] lk_tag;
  logic [IDXW-1:0] upd_idx;
  logic [TAGW-1:0] upd_tag;
  logic            upd_hit;
  bpred_t          upd_state_nxt;

  assign lk_idx  = pc[IDXW+1:2];
  assign lk_tag  = pc[31:IDXW+2];
  assign upd_idx = upd_pc[IDXW+1:2];
  assign upd_tag = upd_pc[31:IDXW+2];

  // Byte-offset bits never participate in indexing or tag compare.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{pc[1:0], upd_pc[1:0]};

  // Lookup: hit on valid tag match, fall through to pc+4 unless predicted taken.
  always_comb begin
    pred_hit   = 1'b0;
    pred_taken = 1'b0;
    pred_npc   = 32'(pc + 32'd4);
    if (valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag)) begin
      pred_hit = 1'b1;
    end
    if (pred_hit && ((state_q[lk_idx] == TH) || (state_q[lk_idx] == TS))) begin
      pred_taken = 1'b1;
      pred_npc   = target_q[lk_idx];
    end
  end

  // Resolution side: hit detection and saturating counter next state.
  always_comb begin
    upd_hit       = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    upd_state_nxt = state_q[upd_idx];
    case (state_q[upd_idx])
      NH:      upd_state_nxt = upd_taken ? NS : NH;
      NS:      upd_state_nxt = upd_taken ? TS : NH;
      TS:      upd_state_nxt = upd_taken ? TH : NS;
      TH:      upd_state_nxt = upd_taken ? TH : TS;
      default: upd_state_nxt = NH;
    endcase
  end

  // Table write: train on hit, allocate only taken branches on miss.
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q  <= '0;
      tag_q    <= '{default: '0};
      target_q <= '{default: '0};
      state_q  <= '{default: NH};
    end else if (upd_en) begin
      if (upd_hit) begin
        state_q[upd_idx] <= upd_state_nxt;
        if (upd_taken) begin
          target_q[upd_idx] <= upd_target;
        end
      end else if (upd_taken) begin
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= upd_target;
        state_q[upd_idx]  <= TS;
      end
    end
  end

`ifdef BTB_STATS_EN
  // Free-running statistics, wrapping modulo 2^32.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stat_lookups     <= '0;
      stat_hits        <= '0;
      stat_mispredicts <= '0;
    end else begin
      stat_lookups <= 32'(stat_lookups + 32'd1);
      if (pred_hit) begin
        stat_hits <= 32'(stat_hits + 32'd1);
      end
      if (upd_en && (upd_taken != upd_pred_taken)) begin
        stat_mispredicts <= 32'(stat_mispredicts + 32'd1);
      end
    end
  end
`else
  // Prediction echo only feeds the statistics.
  logic unused_upd_pred_taken;
  assign unused_upd_pred_taken = upd_pred_taken;
`endif

endmodule : branch_target_buffer

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer (ENTRIES=8).
module tb_branch_target_buffer;

  typedef struct packed {
    logic        hit;
    logic        taken;
    logic [31:0] npc;
  } res_t;

  logic        CLK;
  logic        RST;
  logic [31:0] pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_npc;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
`ifdef BTB_STATS_EN
  logic [31:0] stat_lookups;
  logic [31:0] stat_hits;
  logic [31:0] stat_mispredicts;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  res_t  exp_q[$];
  res_t  obs_q[$];
  string nm_q[$];

  branch_target_buffer #(.ENTRIES(8)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .pc             (pc),
    .pred_hit       (pred_hit),
    .pred_taken     (pred_taken),
    .pred_npc       (pred_npc),
    .upd_en         (upd_en),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_pred_taken (upd_pred_taken)
`ifdef BTB_STATS_EN
    ,
    .stat_lookups     (stat_lookups),
    .stat_hits        (stat_hits),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Hold RST through one rising edge with a pending update that must be ignored.
  task automatic do_reset();
    RST            = 1'b1;
    upd_en         = 1'b1;
    upd_pc         = 32'h0000_0040;
    upd_taken      = 1'b1;
    upd_target     = 32'h0000_0999;
    upd_pred_taken = 1'b0;
    @(posedge CLK);
    #1;
    RST    = 1'b0;
    upd_en = 1'b0;
  endtask

  // One cycle: drive inputs, queue the expectation, capture outputs mid-cycle.
  task automatic drive(input string nm, input logic [31:0] p,
                       input logic ue, input logic [31:0] up, input logic ut,
                       input logic [31:0] utg, input logic upt,
                       input logic eh, input logic et, input logic [31:0] en);
    res_t e;
    res_t o;
    pc             = p;
    upd_en         = ue;
    upd_pc         = up;
    upd_taken      = ut;
    upd_target     = utg;
    upd_pred_taken = upt;
    e = {eh, et, en};
    exp_q.push_back(e);
    nm_q.push_back(nm);
    @(negedge CLK);
    o = {pred_hit, pred_taken, pred_npc};
    obs_q.push_back(o);
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    res_t e, o;
    string n;
    do_reset();
    drive("rst_miss_40", 32'h40,       0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h44);
    drive("rst_wrap",    32'hFFFF_FFFC, 0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL %s: got hit=%0b taken=%0b npc=%h, want hit=%0b taken=%0b npc=%h",
                 n, o.hit, o.taken, o.npc, e.hit, e.taken, e.npc);
      end
    end
  endtask

  task automatic test_alloc();
    res_t e, o;
    string n;
    drive("alloc_upd", 32'h40, 1, 32'h40, 1, 32'h100, 0, 0, 0, 32'h44);
    drive("alloc_hit", 32'h40, 0, 32'h0,  0, 32'h0,   0, 1, 1, 32'h100);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL %s: got hit=%0b taken=%0b npc=%h, want hit=%0b taken=%0b npc=%h",
                 n, o.hit, o.taken, o.npc, e.hit, e.taken, e.npc);
      end
    end
  endtask

  task automatic test_counter_walk();
    res_t e, o;
    string n;
    drive("walk_t_ts",  32'h40, 1, 32'h40, 1, 32'h140,   0, 1, 1, 32'h100);
    drive("walk_t_th",  32'h40, 1, 32'h40, 1, 32'h140,   0, 1, 1, 32'h140);
    drive("walk_nt_th", 32'h40, 1, 32'h40, 0, 32'hDEAD0, 1, 1, 1, 32'h140);
    drive("walk_nt_ts", 32'h40, 1, 32'h40, 0, 32'hDEAD0, 1, 1, 1, 32'h140);
    drive("walk_nt_ns", 32'h40, 1, 32'h40, 0, 32'hDEAD0, 1, 1, 0, 32'h44);
    drive("walk_nt_nh", 32'h40, 1, 32'h40, 0, 32'hDEAD0, 0, 1, 0, 32'h44);
    drive("walk_t_nh",  32'h40, 1, 32'h40, 1, 32'h100,   0, 1, 0, 32'h44);
    drive("walk_t_ns",  32'h40, 1, 32'h40, 1, 32'h100,   0, 1, 0, 32'h44);
    drive("walk_ts",    32'h40, 0, 32'h0,  0, 32'h0,     0, 1, 1, 32'h100);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL %s: got hit=%0b taken=%0b npc=%h, want hit=%0b taken=%0b npc=%h",
                 n, o.hit, o.taken, o.npc, e.hit, e.taken, e.npc);
      end
    end
  endtask

  task automatic test_alias();
    res_t e, o;
    string n;
    drive("alias_nt_upd", 32'h40, 1, 32'h60, 0, 32'h200, 0, 1, 1, 32'h100);
    drive("alias_keep",   32'h40, 0, 32'h0,  0, 32'h0,   0, 1, 1, 32'h100);
    drive("alias_t_upd",  32'h60, 1, 32'h60, 1, 32'h200, 0, 0, 0, 32'h64);
    drive("alias_new",    32'h60, 0, 32'h0,  0, 32'h0,   0, 1, 1, 32'h200);
    drive("alias_evict",  32'h40, 0, 32'h0,  0, 32'h0,   0, 0, 0, 32'h44);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL %s: got hit=%0b taken=%0b npc=%h, want hit=%0b taken=%0b npc=%h",
                 n, o.hit, o.taken, o.npc, e.hit, e.taken, e.npc);
      end
    end
  endtask

  task automatic test_same_cycle();
    res_t e, o;
    string n;
    drive("same_alloc", 32'h40, 1, 32'h40, 1, 32'h100, 0, 0, 0, 32'h44);
    drive("same_old",   32'h40, 1, 32'h40, 0, 32'h0,   1, 1, 1, 32'h100);
    drive("same_new",   32'h40, 0, 32'h0,  0, 32'h0,   0, 1, 0, 32'h44);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL %s: got hit=%0b taken=%0b npc=%h, want hit=%0b taken=%0b npc=%h",
                 n, o.hit, o.taken, o.npc, e.hit, e.taken, e.npc);
      end
    end
  endtask

  task automatic test_reset_midstream();
    res_t e, o;
    string n;
    drive("mid_alloc44", 32'h40, 1, 32'h44, 1, 32'h300, 0, 1, 0, 32'h44);
    drive("mid_hit44",   32'h44, 0, 32'h0,  0, 32'h0,   0, 1, 1, 32'h300);
    do_reset();
    drive("mid_miss40",  32'h40, 0, 32'h0,  0, 32'h0,   0, 0, 0, 32'h44);
    drive("mid_miss44",  32'h44, 0, 32'h0,  0, 32'h0,   0, 0, 0, 32'h48);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL %s: got hit=%0b taken=%0b npc=%h, want hit=%0b taken=%0b npc=%h",
                 n, o.hit, o.taken, o.npc, e.hit, e.taken, e.npc);
      end
    end
  endtask

`ifdef BTB_STATS_EN
  task automatic test_stats();
    res_t e, o;
    string n;
    do_reset();
    drive("st_c1", 32'h40, 1, 32'h40, 1, 32'h100, 0, 0, 0, 32'h44);
    drive("st_c2", 32'h40, 1, 32'h40, 1, 32'h100, 1, 1, 1, 32'h100);
    drive("st_c3", 32'h40, 0, 32'h0,  0, 32'h0,   0, 1, 1, 32'h100);
    drive("st_c4", 32'h40, 0, 32'h0,  0, 32'h0,   0, 1, 1, 32'h100);
    drive("st_c5", 32'h40, 0, 32'h0,  0, 32'h0,   0, 1, 1, 32'h100);
    for (int i = 0; i < 5; i++) begin
      drive("st_miss", 32'h80, 0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h84);
    end
    n_checks++;
    if (stat_lookups !== 32'd10) begin
      n_fail++;
      $display("FAIL stat_lookups: got %0d want 10", stat_lookups);
    end
    n_checks++;
    if (stat_hits !== 32'd4) begin
      n_fail++;
      $display("FAIL stat_hits: got %0d want 4", stat_hits);
    end
    n_checks++;
    if (stat_mispredicts !== 32'd1) begin
      n_fail++;
      $display("FAIL stat_mispredicts: got %0d want 1", stat_mispredicts);
    end
    do_reset();
    n_checks++;
    if ({stat_lookups, stat_hits, stat_mispredicts} !== 96'd0) begin
      n_fail++;
      $display("FAIL stat_clear: got %0d/%0d/%0d want 0/0/0",
               stat_lookups, stat_hits, stat_mispredicts);
    end
    drive("st_rst_miss40", 32'h40, 0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h44);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = nm_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL %s: got hit=%0b taken=%0b npc=%h, want hit=%0b taken=%0b npc=%h",
                 n, o.hit, o.taken, o.npc, e.hit, e.taken, e.npc);
      end
    end
  endtask
`endif

  initial begin
    RST            = 1'b1;
    pc             = '0;
    upd_en         = 1'b0;
    upd_pc         = '0;
    upd_taken      = 1'b0;
    upd_target     = '0;
    upd_pred_taken = 1'b0;
    test_reset();
    test_alloc();
    test_counter_walk();
    test_alias();
    test_same_cycle();
    test_reset_midstream();
`ifdef BTB_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_branch_target_buffer
